// File: rtl/text_pkg.sv
// Shared widths, fill code and clear-sequencer state encoding for the text buffer.
package text_pkg;

  localparam int unsigned COL_BITS = 5;
  localparam int unsigned ROW_BITS = 4;
  localparam int unsigned CHAR_W   = 7;
  localparam logic [CHAR_W-1:0] FILL_CHAR = 7'h20;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StDone
  } state_e;

endpackage

// File: rtl/text_buffer_arbiter_if.sv
// Renderer fetch, host write and clear-control signals of the text buffer arbiter.
interface text_buffer_arbiter_if
  import text_pkg::*;
#(
  parameter int unsigned COL_BITS = text_pkg::COL_BITS,
  parameter int unsigned ROW_BITS = text_pkg::ROW_BITS,
  parameter int unsigned CHAR_W   = text_pkg::CHAR_W
);

  logic                disp_req;
  logic [ROW_BITS-1:0] disp_row;
  logic [COL_BITS-1:0] disp_col;
  logic [CHAR_W-1:0]   disp_char;
  logic                disp_char_valid;

  logic                host_valid;
  logic                host_ready;
  logic [ROW_BITS-1:0] host_row;
  logic [COL_BITS-1:0] host_col;
  logic [CHAR_W-1:0]   host_char;

  logic                clear_start;
  logic                busy;
  logic                clear_done;

  modport master (
    output disp_req, disp_row, disp_col, host_valid, host_row, host_col, host_char, clear_start,
    input  disp_char, disp_char_valid, host_ready, busy, clear_done
  );

  modport slave (
    input  disp_req, disp_row, disp_col, host_valid, host_row, host_col, host_char, clear_start,
    output disp_char, disp_char_valid, host_ready, busy, clear_done
  );

endinterface

// File: rtl/text_ram.sv
// Single-port synchronous character RAM with a one-cycle registered read; contents not reset.
module text_ram #(
  parameter int unsigned AddrW = 9,
  parameter int unsigned DataW = 7
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wdata_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [2**AddrW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/text_buffer_arbiter.sv
// Arbitrates the character RAM between renderer fetches (highest), the clear sequencer and
// host writes (lowest), one RAM access per cycle.
module text_buffer_arbiter
  import text_pkg::*;
#(
  parameter int unsigned       COL_BITS       = text_pkg::COL_BITS,
  parameter int unsigned       ROW_BITS       = text_pkg::ROW_BITS,
  parameter int unsigned       CHAR_W         = text_pkg::CHAR_W,
  parameter logic [CHAR_W-1:0] FILL_CHAR      = text_pkg::FILL_CHAR,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  text_buffer_arbiter_if.slave bus
);

  localparam int unsigned AW = ROW_BITS + COL_BITS;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              after_rst_q;
  logic              valid_q;
  logic [CHAR_W-1:0] hold_q;
  logic              start_clear;
  logic              host_ready;

  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [CHAR_W-1:0] ram_wdata;
  logic [CHAR_W-1:0] ram_rdata;
  logic [CHAR_W-1:0] disp_char;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    start_clear = 1'b0;
    host_ready  = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = {bus.disp_row, bus.disp_col};
    ram_wdata   = FILL_CHAR;
    unique case (state_q)
      StIdle: begin
        start_clear = bus.clear_start | (CLEAR_ON_RESET & after_rst_q);
        if (start_clear) begin
          state_d = StClear;
        end
        // A pending clear takes the cycle away from the host.
        host_ready = rst_n & ~bus.disp_req & ~start_clear;
      end
      StClear: begin
        if (!bus.disp_req) begin
          ram_we   = rst_n;
          ram_addr = cnt_q;
          cnt_d    = cnt_q + 1'b1;
          if (&cnt_q) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (host_ready && bus.host_valid) begin
      ram_we    = 1'b1;
      ram_addr  = {bus.host_row, bus.host_col};
      ram_wdata = bus.host_char;
    end
  end

  // The RAM output register is the fetch result; hold_q keeps it stable between fetches.
  assign disp_char = valid_q ? ram_rdata : hold_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      after_rst_q <= 1'b1;
      valid_q     <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      after_rst_q <= 1'b0;
      valid_q     <= bus.disp_req;
      hold_q      <= disp_char;
    end
  end

  text_ram #(
    .AddrW(AW),
    .DataW(CHAR_W)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  assign bus.disp_char       = disp_char;
  assign bus.disp_char_valid = valid_q;
  assign bus.host_ready      = host_ready;
  assign bus.busy            = (state_q == StClear);
  assign bus.clear_done      = (state_q == StDone);

endmodule
